trng_bit_collector: RTL

- Consumer end of the ring-oscillator TRNG raw bit stream.
- Synchronizes the free-running oscillator output, samples it at a programmable rate, and removes bias with a von Neumann corrector.
- Packs corrected bits into words and hands them to the downstream reader over a valid/ready handshake.
- Sits between the ring oscillator and the TT output/readout logic.

---
 rtl/trng_bit_collector_if.sv | 11 +
 rtl/trng_bit_collector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/trng_bit_collector_if.sv
// Output handshake bundle for trng_bit_collector: assembled word plus valid/ready.
interface trng_bit_collector_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_bit_collector.sv
// TRNG raw-bit collector: 2-flop sync, programmable sample divider,
// von Neumann debias, word packing and a valid/ready holding register.
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_bit_collector #(
  parameter int SAMPLE_DIV = 16,
  parameter int WORD_W     = 8,
  parameter int REP_LIMIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  raw_bit,
  trng_bit_collector_if.master  dif,
  output logic                  overflow,
  output logic                  health_fail
);
  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] HAVE_A = 1'b1;

  logic [1:0]        sync_q;
  logic [DW-1:0]     div_q, div_d;
  logic [0:0]        state_q, state_d;
  logic              a_q, a_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;

  logic raw_s, strobe, emit, word_done, xfer, hf_w;

  assign raw_s     = sync_q[1];
  // Gating with en also drops a strobe landing in the cycle en falls.
  assign strobe    = en & (div_q == DW'(SAMPLE_DIV - 1));
  assign emit      = strobe & (state_q == HAVE_A) & (a_q != raw_s);
  assign word_done = emit & (bit_cnt_q == BW'(WORD_W - 1));
  assign xfer      = dv_q & dif.data_ready;

  // Two-flop synchronizer for the free-running oscillator output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw_bit};
  end

  // Next-state for divider, von Neumann FSM, packer and holding register
  always_comb begin
    div_d     = div_q;
    state_d   = state_q;
    a_d       = a_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = dout_q;
    dv_d      = dv_q & ~xfer;
    ovf_d     = ovf_q;

    if (!en) begin
      div_d     = '0;
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      div_d = strobe ? '0 : div_q + DW'(1);
      if (strobe) begin
        if (state_q == IDLE) begin
          a_d     = raw_s;
          state_d = HAVE_A;
        end else begin
          state_d = IDLE;
        end
      end
      if (emit) begin
        shift_d   = {a_q, shift_q[WORD_W-1:1]};
        bit_cnt_d = word_done ? '0 : bit_cnt_q + BW'(1);
      end
    end

    // A completed word either lands in a free holding register or is dropped;
    // once the health test trips, words vanish silently.
    if (word_done && !hf_w) begin
      if (!dv_q || xfer) begin
        dout_d = shift_d;
        dv_d   = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end
  end

  // Collector state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      state_q   <= IDLE;
      a_q       <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      a_q       <= a_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          last_q;
  logic          hf_q;

  // rep_q==0 means no sample seen yet, so the first sample starts a run of 1
  always_comb begin
    if (rep_q == '0 || raw_s != last_q) rep_d = RW'(1);
    else if (rep_q == RW'(REP_LIMIT))   rep_d = rep_q;
    else                                rep_d = rep_q + RW'(1);
  end

  // Repetition-count test on every raw sample; failure is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else if (strobe) begin
      rep_q  <= rep_d;
      last_q <= raw_s;
      if (rep_d == RW'(REP_LIMIT)) hf_q <= 1'b1;
    end
  end

  assign hf_w = hf_q;
`else
  assign hf_w = 1'b0;
`endif

  assign health_fail    = hf_w;
  assign overflow       = ovf_q;
  assign dif.data_out   = dout_q;
  assign dif.data_valid = dv_q;
endmodule
